evo_delete_gene_pipe: RTL and testbench
=======================================

EVO_DELETE_GENE_PIPE -- requirements
Module: evo_delete_gene_pipe

Interface
REQ-001 Parameter GENE_W, default 64, gene word width; SHALL satisfy GENE_W >= 17+2*ID_W.
REQ-002 Parameter ID_W, default 8, node-ID width.
REQ-003 Parameter MAX_DEL, default 8, deleted-node table depth (>= 1).
REQ-004 Parameter THR_W, default 32, threshold and random-compare width.
REQ-005 Parameter CNT_W, default 16, statistics counter width.
REQ-006 clk  in  1  clock; all state SHALL update on rising edge.
REQ-007 Reset  in  1  reset: synchronous, active-high.
REQ-008 genome_start  in  1  pulse; clears deletion table and statistics for a new genome.
REQ-009 mode  in  2  00 bypass, 01 random delete + dangling prune, 10 dangling prune only, 11 same as 01.
REQ-010 thresh  in  THR_W  delete threshold.
REQ-011 rand_in  in  THR_W  random value, sampled with the accepted gene.
REQ-012 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-013 in_gene  in  GENE_W  gene: TAG [GENE_W-1 -: 8], TYPE [GENE_W-9] (1=connection, 0=node), ID1 [GENE_W-17 -: ID_W], ID2 [GENE_W-17-ID_W -: ID_W].
REQ-014 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-015 out_gene  out  GENE_W  processed gene.
REQ-016 table_full  out  1  high when table holds MAX_DEL entries.
REQ-017 nodes_del / conns_del / sat_cnt  out  CNT_W each  deletion and table-saturation statistics.

Function
REQ-018 Transfer in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-019 in_ready SHALL equal !out_valid | out_ready (single output register, combinational ready).
REQ-020 Latency SHALL be exactly 1 cycle: gene accepted at edge N appears on out_gene with out_valid from edge N.
REQ-021 While out_valid & !out_ready, out_gene and out_valid SHALL hold stable.
REQ-022 out_valid SHALL set on in_fire, clear on out_fire without in_fire.
REQ-023 Gene is "live" when TAG != 8'hFF; non-live genes SHALL pass unchanged, no table/counter effect.
REQ-024 "Hit" = rand_in > thresh (unsigned, strict); equality is not a hit.
REQ-025 Deletion SHALL be output = in_gene with TAG forced to 8'hFF, other bits unchanged.
REQ-026 mode 00: all genes pass unchanged; no table or counter updates.
REQ-027 Live node, mode 01/11, hit, table not full: delete; if ID1 not in table, append ID1; nodes_del += 1.
REQ-028 Live node, hit, ID1 already in table: delete, no append (also when full), nodes_del += 1.
REQ-029 Live node, hit, table full, ID1 not in table: pass unchanged, sat_cnt += 1.
REQ-030 Live node, mode 10 or no hit: pass unchanged.
REQ-031 Live connection, mode 01/11, hit: delete, conns_del += 1.
REQ-032 Live connection, modes 01/10/11, ID1 or ID2 matches any valid table entry: delete, conns_del += 1 (counted once).
REQ-033 Table match SHALL use contents before the current cycle's append.
REQ-034 Table is MAX_DEL entries with per-entry valid; appends fill lowest free index; no wrap, no eviction.
REQ-035 table_full SHALL be registered and reflect the entry count after the current edge.
REQ-036 Counters SHALL saturate at all-ones, never wrap.
REQ-037 genome_start SHALL clear table, table_full and counters at the edge; a gene accepted the same cycle SHALL see an empty table and its updates SHALL apply after the clear.
REQ-038 mode, thresh, rand_in are sampled only at in_fire; changes between transfers SHALL have no effect.

Reset
REQ-039 On Reset: out_valid=0, out_gene=0, table empty, table_full=0, nodes_del=conns_del=sat_cnt=0; in_ready=1 the following cycle.
REQ-040 Reset SHALL take priority over genome_start and in_fire; an in-flight output gene SHALL be discarded.

Verification
REQ-041 mode 01, thresh=100, rand=200, node TAG=01 ID1=05 -> next cycle TAG=FF, table holds 05, nodes_del=1.
REQ-042 Then rand=50, connection ID1=07 ID2=05 -> TAG=FF, conns_del=1; connection 07->09 passes unchanged.
REQ-043 MAX_DEL=2, three hit nodes IDs 1,2,3 -> first two deleted, table_full=1, third unchanged, sat_cnt=1.
REQ-044 out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_gene stable, no gene lost or duplicated; genes in order after release.
REQ-045 genome_start with hit node ID=09 same cycle, table previously {05} -> table={09}, nodes_del=1, subsequent connection 05->07 passes.
REQ-046 rand=thresh=100 on live node -> passes unchanged; TAG=FF gene with hit -> unchanged, counters unchanged.

Source files
------------

// File: rtl/evo_delete_gene_pipe.sv
`default_nettype none
// ============================================================================
// Module   : evo_delete_gene_pipe
// Purpose  : One-stage gene pipeline that randomly deletes node genes and
//            prunes connection genes that touch deleted nodes.
// Revision : 1.0 - initial release
// ============================================================================
module evo_delete_gene_pipe #(
  parameter int GENE_W  = 64,
  parameter int ID_W    = 8,
  parameter int MAX_DEL = 8,
  parameter int THR_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              genome_start,
  input  logic [1:0]        mode,
  input  logic [THR_W-1:0]  thresh,
  input  logic [THR_W-1:0]  rand_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [GENE_W-1:0] in_gene,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GENE_W-1:0] out_gene,
  output logic              table_full,
  output logic [CNT_W-1:0]  nodes_del,
  output logic [CNT_W-1:0]  conns_del,
  output logic [CNT_W-1:0]  sat_cnt
);

  localparam int               c_cw      = $clog2(MAX_DEL + 1);
  localparam logic [c_cw-1:0]  c_max     = c_cw'(MAX_DEL);
  localparam logic [c_cw-1:0]  c_cw_one  = c_cw'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic              r_out_valid;
  logic [GENE_W-1:0] r_out_gene;
  logic [MAX_DEL-1:0] r_tab_v;
  logic [ID_W-1:0]   r_tab_id [MAX_DEL];
  logic [c_cw-1:0]   r_count;
  logic              r_table_full;
  logic [CNT_W-1:0]  r_nodes, r_conns, r_sat;

  logic              w_in_fire;
  logic [7:0]        w_tag;
  logic              w_is_conn, w_live, w_hit, w_rand_mode, w_prune_mode;
  logic [ID_W-1:0]   w_id1, w_id2;
  logic [MAX_DEL-1:0] w_tab_v;
  logic [c_cw-1:0]   w_count, w_count_next;
  logic              w_full, w_m1, w_m2;
  logic              w_node_del, w_node_sat, w_append, w_conn_del, w_delete;
  logic [GENE_W-1:0] w_gene_next;
  logic [CNT_W-1:0]  w_nodes_next, w_conns_next, w_sat_next;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + c_cnt_one : v;
  endfunction

  assign in_ready   = !r_out_valid | out_ready;
  assign w_in_fire  = in_valid & in_ready;
  assign out_valid  = r_out_valid;
  assign out_gene   = r_out_gene;
  assign table_full = r_table_full;
  assign nodes_del  = r_nodes;
  assign conns_del  = r_conns;
  assign sat_cnt    = r_sat;

  assign w_tag        = in_gene[GENE_W-1 -: 8];
  assign w_is_conn    = in_gene[GENE_W-9];
  assign w_id1        = in_gene[GENE_W-17 -: ID_W];
  assign w_id2        = in_gene[GENE_W-17-ID_W -: ID_W];
  assign w_live       = (w_tag != 8'hFF);
  assign w_hit        = (rand_in > thresh);
  assign w_rand_mode  = mode[0];
  assign w_prune_mode = (mode != 2'b00);

  // genome_start empties the table before this cycle's gene looks it up
  assign w_tab_v = genome_start ? '0 : r_tab_v;
  assign w_count = genome_start ? '0 : r_count;
  assign w_full  = (w_count == c_max);

  always_comb begin
    w_m1 = 1'b0;
    w_m2 = 1'b0;
    for (int i = 0; i < MAX_DEL; i++) begin
      if (w_tab_v[i]) begin
        if (r_tab_id[i] == w_id1) w_m1 = 1'b1;
        if (r_tab_id[i] == w_id2) w_m2 = 1'b1;
      end
    end
  end

  assign w_node_del = w_in_fire & w_live & !w_is_conn & w_rand_mode & w_hit & (w_m1 | !w_full);
  assign w_node_sat = w_in_fire & w_live & !w_is_conn & w_rand_mode & w_hit & !w_m1 & w_full;
  assign w_append   = w_in_fire & w_live & !w_is_conn & w_rand_mode & w_hit & !w_m1 & !w_full;
  assign w_conn_del = w_in_fire & w_live & w_is_conn &
                      ((w_rand_mode & w_hit) | (w_prune_mode & (w_m1 | w_m2)));
  assign w_delete   = w_node_del | w_conn_del;

  assign w_gene_next  = w_delete ? {8'hFF, in_gene[GENE_W-9:0]} : in_gene;
  assign w_count_next = w_append ? w_count + c_cw_one : w_count;
  assign w_nodes_next = f_sat_inc(genome_start ? '0 : r_nodes, w_node_del);
  assign w_conns_next = f_sat_inc(genome_start ? '0 : r_conns, w_conn_del);
  assign w_sat_next   = f_sat_inc(genome_start ? '0 : r_sat,   w_node_sat);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_out_valid  <= 1'b0;
      r_out_gene   <= '0;
      r_tab_v      <= '0;
      r_count      <= '0;
      r_table_full <= 1'b0;
      r_nodes      <= '0;
      r_conns      <= '0;
      r_sat        <= '0;
      for (int i = 0; i < MAX_DEL; i++) r_tab_id[i] <= '0;
    end else begin
      if (w_in_fire) begin
        r_out_valid <= 1'b1;
        r_out_gene  <= w_gene_next;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_tab_v <= w_tab_v;
      // entries stay contiguous, so the count is also the next free index
      for (int i = 0; i < MAX_DEL; i++) begin
        if (w_append && (w_count == c_cw'(i))) begin
          r_tab_v[i]  <= 1'b1;
          r_tab_id[i] <= w_id1;
        end
      end
      r_count      <= w_count_next;
      r_table_full <= (w_count_next == c_max);
      r_nodes      <= w_nodes_next;
      r_conns      <= w_conns_next;
      r_sat        <= w_sat_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_evo_delete_gene_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_evo_delete_gene_pipe
// Purpose  : Directed and randomized checks of evo_delete_gene_pipe against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_evo_delete_gene_pipe;

  localparam int GENE_W  = 64;
  localparam int ID_W    = 8;
  localparam int MAX_DEL = 2;
  localparam int THR_W   = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              Reset, genome_start, in_valid, in_ready, out_valid, out_ready, table_full;
  logic [1:0]        mode;
  logic [THR_W-1:0]  thresh, rand_in;
  logic [GENE_W-1:0] in_gene, out_gene;
  logic [CNT_W-1:0]  nodes_del, conns_del, sat_cnt;

  evo_delete_gene_pipe #(
    .GENE_W(GENE_W), .ID_W(ID_W), .MAX_DEL(MAX_DEL), .THR_W(THR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .Reset(Reset), .genome_start(genome_start), .mode(mode),
    .thresh(thresh), .rand_in(rand_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_gene(in_gene), .out_valid(out_valid), .out_ready(out_ready), .out_gene(out_gene),
    .table_full(table_full), .nodes_del(nodes_del), .conns_del(conns_del), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  int          m_tab[$];
  int          m_nodes, m_conns, m_sat;
  bit          m_valid;
  logic [63:0] m_gene;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mk(input logic [7:0] tag, input logic typ,
                                     input logic [7:0] id1, input logic [7:0] id2,
                                     input logic [38:0] f);
    return {tag, typ, f[38:32], id1, id2, f[31:0]};
  endfunction

  function automatic bit in_tab(input int id);
    foreach (m_tab[i]) if (m_tab[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat_add(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  function automatic void model_clear();
    m_tab.delete();
    m_nodes = 0;
    m_conns = 0;
    m_sat   = 0;
  endfunction

  // Applies the deletion rules to one accepted gene and returns what should come out.
  function automatic logic [63:0] model_accept(input logic [63:0] g, input logic [1:0] md,
                                               input int thr, input int rnd);
    int  id1, id2;
    bit  hit, rmode, pmode, del;
    id1   = int'(g[47:40]);
    id2   = int'(g[39:32]);
    hit   = rnd > thr;
    rmode = (md == 2'd1) || (md == 2'd3);
    pmode = (md != 2'd0);
    del   = 1'b0;
    if (g[63:56] != 8'hFF) begin
      if (g[55] == 1'b0) begin
        if (rmode && hit) begin
          if (in_tab(id1)) begin
            del = 1'b1; m_nodes = sat_add(m_nodes);
          end else if (m_tab.size() < MAX_DEL) begin
            del = 1'b1; m_nodes = sat_add(m_nodes); m_tab.push_back(id1);
          end else begin
            m_sat = sat_add(m_sat);
          end
        end
      end else begin
        if ((rmode && hit) || (pmode && (in_tab(id1) || in_tab(id2)))) begin
          del = 1'b1; m_conns = sat_add(m_conns);
        end
      end
    end
    return del ? {8'hFF, g[55:0]} : g;
  endfunction

  task automatic step(input bit iv, input bit ordy, input logic [63:0] g, input logic [1:0] md,
                      input int thr, input int rnd, input bit gs);
    bit exp_ready;
    in_valid = iv; out_ready = ordy; in_gene = g; mode = md;
    thresh = THR_W'(thr); rand_in = THR_W'(rnd); genome_start = gs;
    #1;
    exp_ready = !m_valid || ordy;
    chk("in_ready", in_ready, exp_ready);
    if (gs) model_clear();
    if (iv && exp_ready) begin
      m_gene  = model_accept(g, md, thr, rnd);
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_gene", out_gene, m_gene);
    chk("table_full", table_full, m_tab.size() == MAX_DEL);
    chk("nodes_del", nodes_del, m_nodes);
    chk("conns_del", conns_del, m_conns);
    chk("sat_cnt", sat_cnt, m_sat);
  endtask

  task automatic do_reset();
    Reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; genome_start = 1'b1;
    in_gene = mk(8'h01, 1'b0, 8'd3, 8'd0, 39'h0); mode = 2'd1; thresh = '0; rand_in = '1;
    @(posedge clk); #1;
    model_clear();
    m_valid = 1'b0;
    m_gene  = '0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gene", out_gene, 0);
    chk("rst_table_full", table_full, 0);
    chk("rst_counters", {nodes_del, conns_del, sat_cnt}, 0);
    Reset = 1'b0; in_valid = 1'b0; genome_start = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [63:0] g;
    Reset = 1'b1; genome_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_gene = '0; mode = '0; thresh = '0; rand_in = '0;
    m_valid = 1'b0; m_gene = '0; model_clear();
    @(posedge clk); #1;
    do_reset();

    // random node delete, then prune via table
    g = mk(8'h01, 1'b0, 8'h05, 8'h00, 39'h0);
    step(1, 1, g, 2'd1, 100, 200, 0);
    chk("r041_gene", out_gene, mk(8'hFF, 1'b0, 8'h05, 8'h00, 39'h0));
    chk("r041_nodes", nodes_del, 1);
    step(1, 1, mk(8'h01, 1'b1, 8'h07, 8'h05, 39'h0), 2'd1, 100, 50, 0);
    chk("r042_del", out_gene[63:56], 8'hFF);
    chk("r042_conns", conns_del, 1);
    g = mk(8'h01, 1'b1, 8'h07, 8'h09, 39'h0);
    step(1, 1, g, 2'd1, 100, 50, 0);
    chk("r042_pass", out_gene, g);

    // table saturation
    step(1, 1, mk(8'h02, 1'b0, 8'd1, 8'd0, 39'h0), 2'd1, 100, 200, 1);
    step(1, 1, mk(8'h02, 1'b0, 8'd2, 8'd0, 39'h0), 2'd1, 100, 200, 0);
    chk("r043_full", table_full, 1);
    g = mk(8'h02, 1'b0, 8'd3, 8'd0, 39'h0);
    step(1, 1, g, 2'd1, 100, 200, 0);
    chk("r043_third", out_gene, g);
    chk("r043_sat", sat_cnt, 1);

    // genome_start coincident with a hit
    step(1, 1, mk(8'h03, 1'b0, 8'h05, 8'd0, 39'h0), 2'd1, 100, 200, 1);
    step(1, 1, mk(8'h03, 1'b0, 8'h09, 8'd0, 39'h0), 2'd1, 100, 200, 1);
    chk("r045_nodes", nodes_del, 1);
    g = mk(8'h03, 1'b1, 8'h05, 8'h07, 39'h0);
    step(1, 1, g, 2'd1, 100, 50, 0);
    chk("r045_pass", out_gene, g);

    // equality is not a hit; dead genes untouched
    g = mk(8'h04, 1'b0, 8'h04, 8'd0, 39'h1234);
    step(1, 1, g, 2'd1, 100, 100, 0);
    chk("r046_eq", out_gene, g);
    g = mk(8'hFF, 1'b0, 8'h0A, 8'd0, 39'h55);
    step(1, 1, g, 2'd1, 100, 200, 0);
    chk("r046_dead", out_gene, g);
    chk("r046_nodes", nodes_del, 1);

    // backpressure: output holds while in_ready is low
    step(1, 1, mk(8'h10, 1'b0, 8'd1, 8'd0, 39'h1), 2'd0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, mk(8'h11, 1'b0, 8'd2, 8'd0, 39'h2), 2'd0, 0, 0, 0);
    chk("r044_stall", in_ready, 0);
    step(1, 1, mk(8'h11, 1'b0, 8'd2, 8'd0, 39'h2), 2'd0, 0, 0, 0);
    step(0, 1, '0, 2'd0, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      logic [7:0] tag;
      int thr, rnd;
      tag = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      g   = mk(tag, 1'($urandom), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
               {7'($urandom), 32'($urandom)});
      thr = $urandom_range(0, 300);
      rnd = ($urandom_range(0, 7) == 0) ? thr : $urandom_range(0, 300);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, g, 2'($urandom),
           thr, rnd, $urandom_range(0, 31) == 0);
      if (n == 1800) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
